// File: rtl/controller_pkg.sv
// rtl/controller_pkg.sv - shared encodings and decode record for the multi-cycle controller
//
// Contents: FSM state encoding, opcode/funct codes, ALU_OP width, decode flag
// record, and funct classification helpers used by the decoder.
package controller_pkg;

  localparam int STATE_W  = 3;
  localparam int ALU_OP_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4
  } state_t;

  // Primary opcodes (instruction bits [31:26]); I-format ALU ops occupy 0x08..0x0F
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (instruction bits [5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef struct packed {
    logic                r_type;
    logic                jr;
    logic                jmp;
    logic                jal;
    logic                branch;
    logic                nbranch;
    logic                lw;
    logic                sw;
    logic                reg_dst;
    logic                alu_src;
    logic                i_format;
    logic                sftmd;
    logic [ALU_OP_W-1:0] alu_op;
  } decode_t;

  function automatic logic is_shift_funct(input logic [5:0] fn);
    return fn inside {FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV};
  endfunction

  function automatic logic is_legal_funct(input logic [5:0] fn);
    return is_shift_funct(fn) ||
           (fn inside {FN_JR, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
                       FN_XOR, FN_NOR, FN_SLT, FN_SLTU});
  endfunction

endpackage

// File: rtl/controller_decode.sv
// rtl/controller_decode.sv - combinational instruction decoder
//
// Ports:
//   opcode [5:0]  in   latched instruction bits [31:26]
//   funct  [5:0]  in   latched instruction bits [5:0]
//   dec           out  decode flags (all zero for an illegal instruction)
//   legal         out  instruction is supported
module controller_decode
  import controller_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output decode_t    dec,
  output logic       legal
);

  logic r_op;
  logic i_op;

  always_comb begin
    r_op  = (opcode == OP_RTYPE) && is_legal_funct(funct);
    i_op  = (opcode[5:3] == 3'b001);
    legal = r_op || i_op ||
            (opcode inside {OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_LW, OP_SW});

    dec = '0;
    if (legal) begin
      dec.r_type   = r_op;
      dec.jr       = r_op && (funct == FN_JR);
      dec.jmp      = (opcode == OP_J);
      dec.jal      = (opcode == OP_JAL);
      dec.branch   = (opcode == OP_BEQ);
      dec.nbranch  = (opcode == OP_BNE);
      dec.lw       = (opcode == OP_LW);
      dec.sw       = (opcode == OP_SW);
      dec.reg_dst  = r_op;
      dec.i_format = i_op;
      dec.alu_src  = i_op || (opcode == OP_LW) || (opcode == OP_SW);
      dec.sftmd    = r_op && is_shift_funct(funct);
      dec.alu_op   = {r_op || i_op, (opcode == OP_BEQ) || (opcode == OP_BNE)};
    end
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// rtl/multi_cycle_controller.sv - multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK controller
//
// Ports:
//   clock, reset                  in   system clock, synchronous active-high reset
//   opcode, function_opcode [5:0] in   instruction fields, sampled in FETCH
//   instr_valid                   in   instruction present (FETCH only)
//   alu_result_high               in   upper ALU result, sampled in EXECUTE for lw/sw
//   mem_ready                     in   memory/IO access complete (MEM only)
//   state [2:0]                   out  current FSM state code
//   fetch_req, ir_write, pc_write, instr_done          out  sequencing strobes
//   jr, jmp, jal, branch, nbranch, reg_dst, alu_src,
//   i_format, sftmd, alu_op [1:0]                      out  decode of latched instruction
//   reg_write, mem_read, mem_write, io_read, io_write,
//   memorio_to_reg                                     out  state-qualified strobes
//   illegal_instr, bus_error                           out  single-cycle error pulses
module multi_cycle_controller
  import controller_pkg::*;
#(
  parameter int                         ADDR_HIGH_WIDTH = 22,
  parameter logic [ADDR_HIGH_WIDTH-1:0] IO_BASE_HIGH    = '1,
  parameter int                         MEM_TIMEOUT     = 15
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [5:0]                 opcode,
  input  logic [5:0]                 function_opcode,
  input  logic                       instr_valid,
  input  logic [ADDR_HIGH_WIDTH-1:0] alu_result_high,
  input  logic                       mem_ready,
  output logic [STATE_W-1:0]         state,
  output logic                       fetch_req,
  output logic                       ir_write,
  output logic                       pc_write,
  output logic                       instr_done,
  output logic                       jr,
  output logic                       jmp,
  output logic                       jal,
  output logic                       branch,
  output logic                       nbranch,
  output logic                       reg_dst,
  output logic                       alu_src,
  output logic                       i_format,
  output logic                       sftmd,
  output logic [ALU_OP_W-1:0]        alu_op,
  output logic                       reg_write,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic                       io_read,
  output logic                       io_write,
  output logic                       memorio_to_reg,
  output logic                       illegal_instr,
  output logic                       bus_error
);

  state_t      state_q, state_d;
  logic [5:0]  op_q, fn_q;
  logic        io_sel_q;
  logic [7:0]  wait_cnt_q;
  // Marks the first cycle after reset; no instruction is accepted then so
  // every strobe stays low for that cycle.
  logic        post_reset_q;

  decode_t     dec;
  logic        legal;
  logic        accept;
  logic        timeout_hit;

  controller_decode u_decode (
    .opcode (op_q),
    .funct  (fn_q),
    .dec    (dec),
    .legal  (legal)
  );

  assign accept = (state_q == ST_FETCH) && instr_valid && !post_reset_q;

  // Fires on the last allowed wait cycle; a mem_ready in that same cycle wins.
  assign timeout_hit = (state_q == ST_MEM) && !mem_ready &&
                       (wait_cnt_q == 8'(MEM_TIMEOUT - 1));

  assign state = state_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      op_q         <= '0;
      fn_q         <= '0;
      io_sel_q     <= 1'b0;
      wait_cnt_q   <= '0;
      post_reset_q <= 1'b1;
    end else begin
      post_reset_q <= 1'b0;
      if (accept) begin
        op_q <= opcode;
        fn_q <= function_opcode;
      end
      if (state_q == ST_EXECUTE && (dec.lw || dec.sw)) begin
        io_sel_q <= (alu_result_high == IO_BASE_HIGH);
      end
      // Clearing in EXECUTE means the counter starts at zero on MEM entry.
      if (state_q == ST_EXECUTE) begin
        wait_cnt_q <= '0;
      end else if (state_q == ST_MEM && !mem_ready) begin
        wait_cnt_q <= wait_cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:     if (accept) state_d = ST_DECODE;
      ST_DECODE:    state_d = legal ? ST_EXECUTE : ST_FETCH;
      ST_EXECUTE: begin
        if (dec.jal)                                          state_d = ST_WRITEBACK;
        else if (dec.branch || dec.nbranch || dec.jmp || dec.jr) state_d = ST_FETCH;
        else if (dec.lw || dec.sw)                            state_d = ST_MEM;
        else                                                  state_d = ST_WRITEBACK;
      end
      ST_MEM: begin
        if (mem_ready)        state_d = dec.lw ? ST_WRITEBACK : ST_FETCH;
        else if (timeout_hit) state_d = ST_FETCH;
      end
      ST_WRITEBACK: state_d = ST_FETCH;
      default:      state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    fetch_req      = (state_q == ST_FETCH);
    ir_write       = 1'b0;
    pc_write       = 1'b0;
    instr_done     = 1'b0;
    jr             = 1'b0;
    jmp            = 1'b0;
    jal            = 1'b0;
    branch         = 1'b0;
    nbranch        = 1'b0;
    reg_dst        = 1'b0;
    alu_src        = 1'b0;
    i_format       = 1'b0;
    sftmd          = 1'b0;
    alu_op         = '0;
    reg_write      = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    io_read        = 1'b0;
    io_write       = 1'b0;
    memorio_to_reg = 1'b0;
    illegal_instr  = 1'b0;
    bus_error      = 1'b0;

    if (!reset) begin
      ir_write = accept;
      if (state_q != ST_FETCH) begin
        jr       = dec.jr;
        jmp      = dec.jmp;
        jal      = dec.jal;
        branch   = dec.branch;
        nbranch  = dec.nbranch;
        reg_dst  = dec.reg_dst;
        alu_src  = dec.alu_src;
        i_format = dec.i_format;
        sftmd    = dec.sftmd;
        alu_op   = dec.alu_op;
      end
      case (state_q)
        ST_DECODE: begin
          illegal_instr = !legal;
          instr_done    = !legal;
        end
        ST_EXECUTE: begin
          pc_write   = dec.branch || dec.nbranch || dec.jmp || dec.jr || dec.jal;
          instr_done = dec.branch || dec.nbranch || dec.jmp || dec.jr;
        end
        ST_MEM: begin
          mem_read   = dec.lw && !io_sel_q;
          io_read    = dec.lw && io_sel_q;
          mem_write  = dec.sw && !io_sel_q;
          io_write   = dec.sw && io_sel_q;
          bus_error  = timeout_hit;
          instr_done = timeout_hit || (mem_ready && dec.sw);
        end
        ST_WRITEBACK: begin
          reg_write      = (dec.r_type && !dec.jr) || dec.i_format || dec.lw || dec.jal;
          memorio_to_reg = dec.lw;
          instr_done     = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// tb/tb_multi_cycle_controller.sv - self-checking bench for multi_cycle_controller
module tb_multi_cycle_controller;

  localparam int TIMEOUT = 15;

  // Instruction classes of the reference model
  localparam int C_ILL = 0, C_R = 1, C_JR = 2, C_I = 3, C_LW = 4, C_SW = 5,
                 C_BEQ = 6, C_BNE = 7, C_J = 8, C_JAL = 9;

  // Per-cycle strobe flags of the expected trace
  localparam logic [10:0] F_IRW = 11'h400, F_PCW = 11'h200, F_DONE = 11'h100,
                          F_RW  = 11'h080, F_MR  = 11'h040, F_MW   = 11'h020,
                          F_IOR = 11'h010, F_IOW = 11'h008, F_M2R  = 11'h004,
                          F_ILL = 11'h002, F_BE  = 11'h001;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  opcode, function_opcode;
  logic        instr_valid;
  logic [21:0] alu_result_high;
  logic        mem_ready;
  logic [2:0]  state;
  logic        fetch_req, ir_write, pc_write, instr_done;
  logic        jr, jmp, jal, branch, nbranch, reg_dst, alu_src, i_format, sftmd;
  logic [1:0]  alu_op;
  logic        reg_write, mem_read, mem_write, io_read, io_write, memorio_to_reg;
  logic        illegal_instr, bus_error;

  int checks = 0;
  int errors = 0;

  int r_fn [17] = '{'h00, 'h02, 'h03, 'h04, 'h06, 'h07, 'h08, 'h20, 'h21,
                    'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2A, 'h2B};

  logic [14:0] exp_out [$];
  int          exp_ph  [$];
  bit          exp_rdy [$];

  logic [14:0] act;
  logic [10:0] act_dec;

  assign act = {state, fetch_req, ir_write, pc_write, instr_done, reg_write, mem_read,
                mem_write, io_read, io_write, memorio_to_reg, illegal_instr, bus_error};
  assign act_dec = {jr, jmp, jal, branch, nbranch, reg_dst, alu_src, i_format, sftmd, alu_op};

  always #5 clock = ~clock;

  multi_cycle_controller dut (
    .clock           (clock),
    .reset           (reset),
    .opcode          (opcode),
    .function_opcode (function_opcode),
    .instr_valid     (instr_valid),
    .alu_result_high (alu_result_high),
    .mem_ready       (mem_ready),
    .state           (state),
    .fetch_req       (fetch_req),
    .ir_write        (ir_write),
    .pc_write        (pc_write),
    .instr_done      (instr_done),
    .jr              (jr),
    .jmp             (jmp),
    .jal             (jal),
    .branch          (branch),
    .nbranch         (nbranch),
    .reg_dst         (reg_dst),
    .alu_src         (alu_src),
    .i_format        (i_format),
    .sftmd           (sftmd),
    .alu_op          (alu_op),
    .reg_write       (reg_write),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .io_read         (io_read),
    .io_write        (io_write),
    .memorio_to_reg  (memorio_to_reg),
    .illegal_instr   (illegal_instr),
    .bus_error       (bus_error)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      for (int i = 0; i < 17; i++)
        if (int'(fn) == r_fn[i]) return (fn == 6'h08) ? C_JR : C_R;
      return C_ILL;
    end
    if (op >= 6'h08 && op <= 6'h0F) return C_I;
    case (op)
      6'h02:   return C_J;
      6'h03:   return C_JAL;
      6'h04:   return C_BEQ;
      6'h05:   return C_BNE;
      6'h23:   return C_LW;
      6'h2B:   return C_SW;
      default: return C_ILL;
    endcase
  endfunction

  function automatic logic [10:0] exp_dec(input int cls, input logic [5:0] fn);
    logic rt;
    rt = (cls == C_R) || (cls == C_JR);
    return {cls == C_JR, cls == C_J, cls == C_JAL, cls == C_BEQ, cls == C_BNE, rt,
            (cls == C_I) || (cls == C_LW) || (cls == C_SW), cls == C_I,
            (cls == C_R) && (fn < 6'h08), rt || (cls == C_I),
            (cls == C_BEQ) || (cls == C_BNE)};
  endfunction

  task automatic expect_cycle(input int st, input logic [10:0] flags, input bit rdy);
    exp_out.push_back({3'(st), st == 0, flags});
    exp_ph.push_back(st);
    exp_rdy.push_back(rdy);
  endtask

  // One instruction from FETCH back to FETCH; waits = wait cycles before mem_ready
  // (anything >= TIMEOUT means mem_ready never comes).
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic [21:0] addr, input int waits);
    int          cls;
    bit          io, fin;
    logic [10:0] ed, strobe;
    cls = classify(op, fn);
    io  = (addr == 22'h3FFFFF);
    ed  = exp_dec(cls, fn);
    exp_out.delete(); exp_ph.delete(); exp_rdy.delete();

    expect_cycle(0, F_IRW, 0);
    if (cls == C_ILL) begin
      expect_cycle(1, F_ILL | F_DONE, 0);
    end else begin
      expect_cycle(1, 11'h0, 0);
      case (cls)
        C_BEQ, C_BNE, C_J, C_JR: expect_cycle(2, F_PCW | F_DONE, 0);
        C_JAL: begin expect_cycle(2, F_PCW, 0); expect_cycle(4, F_RW | F_DONE, 0); end
        C_R, C_I: begin expect_cycle(2, 11'h0, 0); expect_cycle(4, F_RW | F_DONE, 0); end
        default: begin
          expect_cycle(2, 11'h0, 0);
          strobe = (cls == C_LW) ? (io ? F_IOR : F_MR) : (io ? F_IOW : F_MW);
          fin = 0;
          for (int k = 0; !fin; k++) begin
            if (k == waits) begin
              fin = 1;
              if (cls == C_SW) expect_cycle(3, strobe | F_DONE, 1);
              else begin
                expect_cycle(3, strobe, 1);
                expect_cycle(4, F_RW | F_M2R | F_DONE, 0);
              end
            end else if (k == TIMEOUT - 1) begin
              fin = 1;
              expect_cycle(3, strobe | F_BE | F_DONE, 0);
            end else begin
              expect_cycle(3, strobe, 0);
            end
          end
        end
      endcase
    end

    for (int i = 0; i < exp_out.size(); i++) begin
      mem_ready = (exp_ph[i] == 3) ? exp_rdy[i] : 1'($urandom);
      if (exp_ph[i] == 0) begin
        instr_valid = 1'b1; opcode = op; function_opcode = fn;
      end else begin
        instr_valid = 1'($urandom); opcode = 6'($urandom); function_opcode = 6'($urandom);
      end
      alu_result_high = (exp_ph[i] == 2) ? addr : 22'($urandom);
      @(negedge clock);
      checks++;
      if (act !== exp_out[i]) begin
        errors++;
        $display("FAIL %s cycle %0d outputs act=%b exp=%b", name, i, act, exp_out[i]);
      end
      checks++;
      if (act_dec !== ((exp_ph[i] == 0) ? 11'h0 : ed)) begin
        errors++;
        $display("FAIL %s cycle %0d decode act=%b exp=%b", name, i, act_dec,
                 (exp_ph[i] == 0) ? 11'h0 : ed);
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      instr_valid = 1'b1; mem_ready = 1'b1;
      opcode = 6'($urandom); function_opcode = 6'($urandom);
      alu_result_high = 22'($urandom);
      @(negedge clock);
      checks++;
      if (state !== 3'd0 || act[10:0] !== 11'h0 || act_dec !== 11'h0) begin
        errors++;
        $display("FAIL reset_hold state=%0d strobes=%b dec=%b exp 0", state, act[10:0], act_dec);
      end
      tick();
    end
    reset = 1'b0;
    instr_valid = 1'b1; opcode = 6'h00; function_opcode = 6'h20;
    @(negedge clock);
    checks++;
    if (state !== 3'd0 || act[10:0] !== 11'h0 || act_dec !== 11'h0) begin
      errors++;
      $display("FAIL reset_after state=%0d strobes=%b dec=%b exp 0", state, act[10:0], act_dec);
    end
    tick();
  endtask

  task automatic test_rtype_add();
    run_instr("rtype_add", 6'h00, 6'h20, 22'($urandom), 0);
  endtask

  task automatic test_lw_io();
    run_instr("lw_io", 6'h23, 6'($urandom), 22'h3FFFFF, 2);
  endtask

  task automatic test_sw_timeout();
    run_instr("sw_timeout", 6'h2B, 6'($urandom), 22'h000001, 1000);
  endtask

  task automatic test_sw_ready_at_limit();
    run_instr("sw_limit", 6'h2B, 6'($urandom), 22'h000001, TIMEOUT - 1);
    run_instr("lw_limit", 6'h23, 6'($urandom), 22'h000002, TIMEOUT - 1);
  endtask

  task automatic test_illegal();
    run_instr("illegal_op", 6'h3F, 6'($urandom), 22'($urandom), 0);
    run_instr("illegal_funct", 6'h00, 6'h01, 22'($urandom), 0);
  endtask

  task automatic test_back_to_back();
    logic [5:0]  op, fn;
    logic [21:0] addr;
    int          waits;
    for (int n = 0; n < 60; n++) begin
      fn = 6'($urandom);
      case ($urandom_range(0, 5))
        0:       begin op = 6'h00; fn = 6'(r_fn[$urandom_range(0, 16)]); end
        1:       op = 6'($urandom_range(8, 15));
        2:       op = 6'($urandom_range(2, 5));
        3, 4:    op = $urandom_range(0, 1) ? 6'h23 : 6'h2B;
        default: op = 6'($urandom);
      endcase
      addr  = $urandom_range(0, 1) ? 22'h3FFFFF : 22'($urandom);
      waits = $urandom_range(0, 18);
      run_instr("random", op, fn, addr, waits);
    end
  endtask

  task automatic test_reset_in_mem();
    instr_valid = 1'b1; opcode = 6'h23; function_opcode = 6'($urandom);
    mem_ready = 1'b0; alu_result_high = 22'h0;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (state !== 3'd3 || mem_read !== 1'b1) begin
        errors++;
        $display("FAIL rst_mem_pre state=%0d mem_read=%b exp 3/1", state, mem_read);
      end
      tick();
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (mem_read !== 1'b0 || reg_write !== 1'b0) begin
      errors++;
      $display("FAIL rst_mem_during mem_read=%b reg_write=%b exp 0/0", mem_read, reg_write);
    end
    tick();
    reset = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (state !== 3'd0 || mem_read !== 1'b0 || reg_write !== 1'b0 || memorio_to_reg !== 1'b0) begin
        errors++;
        $display("FAIL rst_mem_after%0d state=%0d mem_read=%b reg_write=%b exp 0/0/0",
                 i, state, mem_read, reg_write);
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; instr_valid = 1'b0; mem_ready = 1'b0;
    opcode = '0; function_opcode = '0; alu_result_high = '0;
    tick();
    test_reset();
    test_rtype_add();
    test_lw_io();
    test_sw_timeout();
    test_sw_ready_at_limit();
    test_illegal();
    test_back_to_back();
    test_reset_in_mem();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_cycle_controller.md
MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 SHALL have parameter ADDR_HIGH_WIDTH, default 22; number of upper ALU-result bits used for memory/IO address decode.
REQ-002 SHALL have parameter IO_BASE_HIGH, default all-ones of ADDR_HIGH_WIDTH; upper-address value selecting IO space.
REQ-003 SHALL have parameter MEM_TIMEOUT, default 15; maximum wait cycles in MEM before bus error (legal range 1..255).
REQ-004 clock  input  1  single system clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 opcode  input  6  instruction bits [31:26]; function_opcode  input  6  instruction bits [5:0].
REQ-007 instr_valid  input  1  fetched instruction present on opcode/function_opcode.
REQ-008 alu_result_high  input  ADDR_HIGH_WIDTH  upper ALU result bits, valid in EXECUTE.
REQ-009 mem_ready  input  1  memory/IO access complete.
REQ-010 state  output  3  current FSM state code.
REQ-011 fetch_req, ir_write, pc_write, instr_done  output  1 each  fetch request, instruction latch strobe, PC update strobe, completion pulse.
REQ-012 jr, jmp, jal, branch, nbranch, reg_dst, alu_src, i_format, sftmd  output  1 each  decode of latched instruction.
REQ-013 alu_op  output  2  {R-type or I-format, beq or bne}.
REQ-014 reg_write, mem_read, mem_write, io_read, io_write, memorio_to_reg  output  1 each  state-qualified strobes.
REQ-015 illegal_instr, bus_error  output  1 each  single-cycle error pulses.

Function
REQ-016 States SHALL be FETCH(0), DECODE(1), EXECUTE(2), MEM(3), WRITEBACK(4).
REQ-017 FETCH: fetch_req=1; on instr_valid, ir_write=1, opcode/funct latched, next DECODE; else stay.
REQ-018 DECODE: unsupported opcode, or R-type with unsupported funct -> illegal_instr pulse, instr_done pulse, next FETCH; else next EXECUTE.
REQ-019 Decode outputs SHALL derive only from latched opcode/funct, stable from DECODE until return to FETCH; zero in FETCH.
REQ-020 EXECUTE: beq/bne/j/jr -> pc_write=1, instr_done=1, next FETCH; jal -> pc_write=1, next WRITEBACK; lw/sw -> latch io_sel = (alu_result_high == IO_BASE_HIGH), next MEM; R-type/I-format -> next WRITEBACK.
REQ-021 MEM: lw asserts mem_read (io_sel=0) or io_read (io_sel=1); sw asserts mem_write or io_write; exactly one per cycle, held until exit.
REQ-022 MEM exit on mem_ready: lw -> WRITEBACK; sw -> instr_done, FETCH.
REQ-023 MEM wait counter SHALL clear on MEM entry, increment each cycle without mem_ready; after MEM_TIMEOUT wait cycles -> bus_error + instr_done pulse, next FETCH, no write.
REQ-024 mem_ready on the same cycle the timeout is reached SHALL win (normal completion, no bus_error).
REQ-025 WRITEBACK: reg_write=1 for R-type (except jr), I-format, lw, jal; memorio_to_reg=1 for lw only; instr_done=1; next FETCH.
REQ-026 sftmd=1 for R-type funct sll, srl, sra, sllv, srlv, srav only.
REQ-027 Latency with instr_valid at FETCH: branch/jump 3 cycles; R/I/jal 4; sw 4+waits; lw 5+waits.
REQ-028 instr_valid outside FETCH and mem_ready outside MEM SHALL be ignored.

Reset
REQ-029 reset SHALL force state FETCH, latched opcode/funct to 0, wait counter and io_sel to 0.
REQ-030 During and the cycle after reset every output except state and fetch_req SHALL be 0; reset mid-MEM drops strobes in the next cycle with no write.

Structure
REQ-031 Opcode/funct codes, state encodings and ALU_OP width SHALL live in shared package controller_pkg.
REQ-032 Combinational decode SHALL be sub-module controller_decode (opcode, funct -> decode flags, legality); FSM, counter and strobe qualification in top.

Verification
REQ-033 R-type add (op 0x00, funct 0x20), instr_valid held -> states 0,1,2,4; reg_write and reg_dst =1 in WRITEBACK; instr_done in cycle 4.
REQ-034 lw (0x23), alu_result_high=0x3FFFFF, mem_ready after 2 waits -> io_read 3 cycles, mem_read 0, memorio_to_reg+reg_write in WRITEBACK.
REQ-035 sw (0x2B), alu_result_high=0x000001, mem_ready never -> mem_write 15 cycles, then bus_error=1, next state FETCH, reg_write never 1.
REQ-036 sw, mem_ready asserted exactly on wait cycle 15 -> completion, bus_error stays 0.
REQ-037 Opcode 0x3F -> illegal_instr pulse in DECODE, back to FETCH, no pc_write/reg_write.
REQ-038 reset asserted in MEM during lw -> next cycle state=FETCH, mem_read=0, reg_write never asserted for that lw.
